// File: rtl/pspin_pkt_alloc_pkg.sv
// Shared definitions for the PsPIN packet-buffer allocator.
// Holds the FSM state type and the default buffer geometry used by ingress DMA
// and the feedback path; helpers convert between slot indices and byte offsets.
package pspin_pkt_alloc_pkg;

   // Default geometry: 64-byte slots (one AXIS beat), 2048-slot L2 packet region.
   localparam int unsigned DEF_SLOT_BYTES = 64;
   localparam int unsigned DEF_BUF_SLOTS  = 2048;
   localparam int unsigned DEF_TAG_WIDTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // ready for a new request
      ST_CALC = 2'd1,   // slot count / oversize / first fit attempt
      ST_WAIT = 2'd2,   // no room yet; retry every cycle
      ST_RESP = 2'd3    // response held until consumed
   } alloc_state_e;

   // Slot index to byte offset (slot size is a power of two).
   function automatic logic [31:0] slots_to_bytes(input logic [31:0] slots,
                                                  input int unsigned slot_bytes);
      return slots << $clog2(slot_bytes);
   endfunction

endpackage

// File: rtl/pspin_alloc_tag_table.sv
// In-flight allocation table: one entry {slots, done} per tag, used as a circular queue.
// Ports: commit (push at alloc_ptr), free (mark done by tag, flags bad tags),
// retire (pop head), full/empty and head-entry status for the owner.
module pspin_alloc_tag_table #(
   parameter int unsigned TAG_WIDTH = 4,
   parameter int unsigned SLOTS_W   = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 commit_i,
   input  logic [SLOTS_W-1:0]   commit_slots_i,
   output logic [TAG_WIDTH-1:0] commit_tag_o,
   input  logic                 free_i,
   input  logic [TAG_WIDTH-1:0] free_tag_i,
   output logic                 free_bad_o,
   input  logic                 retire_i,
   output logic                 head_done_o,
   output logic [SLOTS_W-1:0]   head_slots_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
   localparam logic [TAG_WIDTH:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

   typedef struct packed {
      logic [SLOTS_W-1:0] slots;   // slots charged, including any wrap padding
      logic               done;    // released by the handler, awaiting retire
   } entry_t;

   entry_t               tbl_q [DEPTH];
   logic [TAG_WIDTH:0]   alloc_ptr_q, retire_ptr_q;   // extra MSB is the wrap bit
   logic [TAG_WIDTH:0]   count;
   logic [TAG_WIDTH-1:0] alloc_idx, retire_idx, free_off;
   logic                 free_hit, free_ok;

   assign alloc_idx    = alloc_ptr_q[TAG_WIDTH-1:0];
   assign retire_idx   = retire_ptr_q[TAG_WIDTH-1:0];
   assign count        = alloc_ptr_q - retire_ptr_q;
   assign empty_o      = (alloc_ptr_q == retire_ptr_q);
   assign full_o       = (alloc_idx == retire_idx) &&
                         (alloc_ptr_q[TAG_WIDTH] != retire_ptr_q[TAG_WIDTH]);
   assign commit_tag_o = alloc_idx;
   assign head_done_o  = tbl_q[retire_idx].done;
   assign head_slots_o = tbl_q[retire_idx].slots;

   // A tag is in flight when its distance from the retire pointer is below the
   // occupancy; a second release of an already-done entry is also rejected.
   assign free_off   = free_tag_i - retire_idx;
   assign free_hit   = ({1'b0, free_off} < count);
   assign free_ok    = free_i && free_hit && !tbl_q[free_tag_i].done;
   assign free_bad_o = free_i && !free_ok;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alloc_ptr_q  <= '0;
         retire_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         if (commit_i) begin
            tbl_q[alloc_idx] <= '{slots: commit_slots_i, done: 1'b0};
            alloc_ptr_q      <= alloc_ptr_q + PTR_ONE;
         end
         if (free_ok) begin
            tbl_q[free_tag_i].done <= 1'b1;
         end
         if (retire_i) begin
            tbl_q[retire_idx].done <= 1'b0;
            retire_ptr_q           <= retire_ptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/pspin_pkt_alloc.sv
// Ring-buffer allocator for the PsPIN L2 packet buffer: ingress DMA asks for a byte
// length, gets a slot-aligned address and a tag; handlers release by tag in any order,
// space is reclaimed in allocation order. Ports: s_alloc_* request, m_alloc_* response,
// s_free_* release, used_slots occupancy, err_* one-cycle error pulses.
module pspin_pkt_alloc
   import pspin_pkt_alloc_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BUF_BASE  = '0,
   parameter int unsigned          SLOT_BYTES = DEF_SLOT_BYTES,
   parameter int unsigned          BUF_SLOTS  = DEF_BUF_SLOTS,
   parameter int unsigned          LEN_WIDTH  = 16,
   parameter int unsigned          TAG_WIDTH  = DEF_TAG_WIDTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [LEN_WIDTH-1:0]        s_alloc_len,
   input  logic                        s_alloc_valid,
   output logic                        s_alloc_ready,
   output logic [ADDR_WIDTH-1:0]       m_alloc_addr,
   output logic [TAG_WIDTH-1:0]        m_alloc_tag,
   output logic                        m_alloc_valid,
   input  logic                        m_alloc_ready,
   input  logic [TAG_WIDTH-1:0]        s_free_tag,
   input  logic                        s_free_valid,
   output logic                        s_free_ready,
   output logic [$clog2(BUF_SLOTS):0]  used_slots,
   output logic                        err_oversize,
   output logic                        err_bad_free
);

   localparam int unsigned SLOT_W = $clog2(BUF_SLOTS);
   localparam int unsigned USED_W = SLOT_W + 1;
   // Working width for fit arithmetic: holds any slot count derived from a length
   // plus a buffer-sized term without overflow.
   localparam int unsigned CW     = ((LEN_WIDTH > SLOT_W) ? LEN_WIDTH : SLOT_W) + 2;
   localparam logic [CW-1:0]     N_C     = CW'(BUF_SLOTS);
   localparam logic [CW-1:0]     ROUND_C = CW'(SLOT_BYTES - 1);
   localparam logic [USED_W-1:0] FULL_U  = USED_W'(BUF_SLOTS);

   alloc_state_e          state_q;
   logic                  alloc_rdy_q, free_rdy_q, valid_q, err_over_q, err_bad_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [SLOT_W-1:0]     head_q, tail_q, head_d, tail_d;
   logic [USED_W-1:0]     used_q, used_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [TAG_WIDTH-1:0]  tag_q;

   logic [CW-1:0]         n_c, head_c, tail_c, contig_c, pad_c, commit_slots_c;
   logic                  oversize, buf_full, end_free, fit_a, fit_b, fit;
   logic                  commit, retire;
   logic [SLOT_W-1:0]     addr_slot;
   logic [ADDR_WIDTH-1:0] addr_bytes;

   logic [TAG_WIDTH-1:0]  tt_commit_tag;
   logic                  tt_free_bad, tt_head_done, tt_full, tt_empty;
   logic [USED_W-1:0]     tt_head_slots;

   pspin_alloc_tag_table #(
      .TAG_WIDTH (TAG_WIDTH),
      .SLOTS_W   (USED_W)
   ) u_tag_table (
      .clk            (clk),
      .rstn           (rstn),
      .commit_i       (commit),
      .commit_slots_i (USED_W'(commit_slots_c)),
      .commit_tag_o   (tt_commit_tag),
      .free_i         (s_free_valid),
      .free_tag_i     (s_free_tag),
      .free_bad_o     (tt_free_bad),
      .retire_i       (retire),
      .head_done_o    (tt_head_done),
      .head_slots_o   (tt_head_slots),
      .full_o         (tt_full),
      .empty_o        (tt_empty)
   );

   // Oldest entry leaves as soon as its handler has released it.
   assign retire = !tt_empty && tt_head_done;

   always_comb begin
      n_c = (CW'(len_q) + ROUND_C) >> $clog2(SLOT_BYTES);
      if (len_q == '0) begin
         n_c = CW'(1);   // zero-length frames still occupy one slot
      end
      oversize = (n_c > N_C);

      head_c = CW'(head_q);
      tail_c = CW'(tail_q);
      // head==tail is ambiguous; occupancy decides between empty and full.
      buf_full = (used_q == FULL_U);
      end_free = !buf_full && (head_q >= tail_q);
      if (buf_full) begin
         contig_c = '0;
      end else if (head_q >= tail_q) begin
         contig_c = N_C - head_c;
      end else begin
         contig_c = tail_c - head_c;
      end
      pad_c = N_C - head_c;

      // Either place at head, or skip the unused tail end and place at slot 0,
      // charging the skipped slots to this entry so retire returns them too.
      fit_a = !tt_full && !oversize && (head_c + n_c <= N_C) && (n_c <= contig_c);
      fit_b = !tt_full && !oversize && (head_c + n_c > N_C) && (n_c <= tail_c) && end_free;
      fit   = fit_a || fit_b;

      addr_slot      = fit_b ? '0 : head_q;
      commit_slots_c = fit_b ? (n_c + pad_c) : n_c;
      commit         = fit && ((state_q == ST_CALC) || (state_q == ST_WAIT));

      addr_bytes = BUF_BASE + ADDR_WIDTH'(slots_to_bytes(32'(addr_slot), SLOT_BYTES));

      // Buffer size is a power of two, so truncation is the modulo wrap.
      head_d = commit ? SLOT_W'(CW'(addr_slot) + n_c) : head_q;
      tail_d = retire ? SLOT_W'(tail_c + CW'(tt_head_slots)) : tail_q;
      used_d = used_q
             + (commit ? USED_W'(commit_slots_c) : '0)
             - (retire ? tt_head_slots : '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         alloc_rdy_q <= 1'b0;
         free_rdy_q  <= 1'b0;
         valid_q     <= 1'b0;
         err_over_q  <= 1'b0;
         err_bad_q   <= 1'b0;
         len_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         used_q      <= '0;
         addr_q      <= '0;
         tag_q       <= '0;
      end else begin
         free_rdy_q <= 1'b1;
         err_over_q <= 1'b0;
         err_bad_q  <= tt_free_bad;
         head_q     <= head_d;
         tail_q     <= tail_d;
         used_q     <= used_d;

         unique case (state_q)
            ST_IDLE: begin
               if (alloc_rdy_q && s_alloc_valid) begin
                  len_q       <= s_alloc_len;
                  alloc_rdy_q <= 1'b0;
                  state_q     <= ST_CALC;
               end else begin
                  alloc_rdy_q <= 1'b1;
               end
            end
            ST_CALC: begin
               if (oversize) begin
                  err_over_q  <= 1'b1;
                  alloc_rdy_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (fit) begin
                  valid_q <= 1'b1;
                  addr_q  <= addr_bytes;
                  tag_q   <= tt_commit_tag;
                  state_q <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (fit) begin
                  valid_q <= 1'b1;
                  addr_q  <= addr_bytes;
                  tag_q   <= tt_commit_tag;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (m_alloc_ready) begin
                  valid_q     <= 1'b0;
                  alloc_rdy_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_alloc_ready = alloc_rdy_q;
   assign m_alloc_addr  = addr_q;
   assign m_alloc_tag   = tag_q;
   assign m_alloc_valid = valid_q;
   assign s_free_ready  = free_rdy_q;
   assign used_slots    = used_q;
   assign err_oversize  = err_over_q;
   assign err_bad_free  = err_bad_q;

endmodule
